// File: rtl/watch_core_param.sv
// watch_core_param: HH:MM:SS watch core with 12/24-hour mode, button-driven
// set mode (RUN -> SET_H -> SET_M -> SET_S), add/sub auto-repeat and an idle
// timeout that falls back to RUN.
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   pulse_1hz            one-cycle strobe per second
//   pulse_500ms          blink phase level (1 = visible)
//   mode/add/sub_button  debounced, synchronised button levels
//   d1..d8               display words {en, bcd[3:0], dp}; d8 = hour tens
//   pm                   PM flag (always 0 when HOUR_24 = 1)
//   mode                 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
// Build option: define WATCH_COLON_BLINK_EN to drive d6/d3 with the colon
// glyph (code A), blinking in RUN and steady in SET states.
module watch_core_param #(
   parameter int HOUR_24       = 1,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int TIMEOUT_S     = 30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pulse_1hz,
   input  logic       pulse_500ms,
   input  logic       mode_button,
   input  logic       add_button,
   input  logic       sub_button,
   output logic [5:0] d1,
   output logic [5:0] d2,
   output logic [5:0] d3,
   output logic [5:0] d4,
   output logic [5:0] d5,
   output logic [5:0] d6,
   output logic [5:0] d7,
   output logic [5:0] d8,
   output logic       pm,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } mode_t;

   localparam int RPT_MAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RPT_MAX + 2);
   localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

   localparam logic [RW-1:0] DELAY_C  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] PERIOD_C = RW'(REPEAT_PERIOD);
   localparam logic [TW-1:0] TO_LAST  =
      (TIMEOUT_S > 0) ? TW'(TIMEOUT_S - 1) : '0;
   localparam logic [7:0]    HOUR_RST = (HOUR_24 != 0) ? 8'h00 : 8'h12;

   // BCD helpers; hour helpers return {pm_toggle, hour}
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [7:0] ms_inc(input logic [7:0] v);
      return (v == 8'h59) ? 8'h00 : bcd_inc(v);
   endfunction

   function automatic logic [7:0] ms_dec(input logic [7:0] v);
      return (v == 8'h00) ? 8'h59 : bcd_dec(v);
   endfunction

   function automatic logic [8:0] hr_inc(input logic [7:0] v);
      if (HOUR_24 != 0) return {1'b0, (v == 8'h23) ? 8'h00 : bcd_inc(v)};
      if (v == 8'h12) return {1'b0, 8'h01};
      if (v == 8'h11) return {1'b1, 8'h12};
      return {1'b0, bcd_inc(v)};
   endfunction

   function automatic logic [8:0] hr_dec(input logic [7:0] v);
      if (HOUR_24 != 0) return {1'b0, (v == 8'h00) ? 8'h23 : bcd_dec(v)};
      if (v == 8'h01) return {1'b0, 8'h12};
      if (v == 8'h12) return {1'b1, 8'h11};
      return {1'b0, bcd_dec(v)};
   endfunction

   mode_t             mode_q, mode_d;
   logic [7:0]        hr_q, hr_d;
   logic [7:0]        mn_q, mn_d;
   logic [7:0]        sc_q, sc_d;
   logic              pm_q, pm_d;
   logic [TW-1:0]     to_q, to_d;
   logic              mode_prev_q, mode_prev_d;
   logic [1:0]        btn_prev_q, btn_prev_d;
   logic [1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [1:0]        rpt_arm_q, rpt_arm_d;
   logic [7:0][5:0]   disp_q, disp_d;

   logic [1:0] btn_now;
   logic [1:0] btn_rise;
   logic [1:0] rpt_fire;
   logic       mode_ev;
   logic       add_ev;
   logic       sub_ev;
   logic       any_ev;
   logic       add_do;
   logic       sub_do;
   logic       to_hit;
   logic [8:0] hr_step;

   assign btn_now     = {sub_button, add_button};
   assign btn_prev_d  = btn_now;
   assign mode_prev_d = mode_button;
   assign btn_rise    = btn_now & ~btn_prev_q;
   assign mode_ev     = mode_button & ~mode_prev_q;

   // Index 0 = add, 1 = sub. A counter value of 0 means idle; the first
   // step fires after REPEAT_DELAY cycles, later ones every REPEAT_PERIOD.
   always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      rpt_arm_d = rpt_arm_q;
      rpt_fire  = '0;
      for (int i = 0; i < 2; i++) begin
         if (!btn_now[i] || mode_q == RUN || REPEAT_DELAY == 0) begin
            rpt_cnt_d[i] = '0;
            rpt_arm_d[i] = 1'b0;
         end else if (btn_rise[i]) begin
            rpt_cnt_d[i] = RW'(1);
            rpt_arm_d[i] = 1'b0;
         end else if (rpt_cnt_q[i] != '0) begin
            if ((!rpt_arm_q[i] && rpt_cnt_q[i] == DELAY_C) ||
                (rpt_arm_q[i] && rpt_cnt_q[i] == PERIOD_C)) begin
               rpt_fire[i]  = 1'b1;
               rpt_cnt_d[i] = RW'(1);
               rpt_arm_d[i] = 1'b1;
            end else begin
               rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
         end
      end
   end

   assign add_ev = btn_rise[0] | rpt_fire[0];
   assign sub_ev = btn_rise[1] | rpt_fire[1];
   assign any_ev = mode_ev | add_ev | sub_ev;
   // mode beats add/sub; add with sub cancels both
   assign add_do = add_ev & ~sub_ev & ~mode_ev;
   assign sub_do = sub_ev & ~add_ev & ~mode_ev;
   // a button event in the expiry cycle restarts the idle count instead
   assign to_hit = (TIMEOUT_S != 0) && (mode_q != RUN) && pulse_1hz &&
                   !any_ev && (to_q == TO_LAST);

   always_comb begin
      hr_d    = hr_q;
      mn_d    = mn_q;
      sc_d    = sc_q;
      pm_d    = pm_q;
      mode_d  = mode_q;
      hr_step = {1'b0, hr_q};
      unique case (mode_q)
         RUN: begin
            if (pulse_1hz) begin
               sc_d = ms_inc(sc_q);
               if (sc_q == 8'h59) begin
                  mn_d = ms_inc(mn_q);
                  if (mn_q == 8'h59) begin
                     hr_step = hr_inc(hr_q);
                     hr_d    = hr_step[7:0];
                     pm_d    = pm_q ^ hr_step[8];
                  end
               end
            end
            if (mode_ev) mode_d = SET_H;
         end
         SET_H: begin
            if (add_do) hr_step = hr_inc(hr_q);
            else if (sub_do) hr_step = hr_dec(hr_q);
            if (add_do || sub_do) begin
               hr_d = hr_step[7:0];
               pm_d = pm_q ^ hr_step[8];
            end
            if (mode_ev) mode_d = SET_M;
            else if (to_hit) mode_d = RUN;
         end
         SET_M: begin
            if (add_do) mn_d = ms_inc(mn_q);
            else if (sub_do) mn_d = ms_dec(mn_q);
            if (mode_ev) mode_d = SET_S;
            else if (to_hit) mode_d = RUN;
         end
         SET_S: begin
            if (add_do) sc_d = ms_inc(sc_q);
            else if (sub_do) sc_d = ms_dec(sc_q);
            if (mode_ev || to_hit) mode_d = RUN;
         end
      endcase

      if (mode_q == RUN || mode_d != mode_q || any_ev) to_d = '0;
      else if (pulse_1hz && TIMEOUT_S != 0) to_d = to_q + TW'(1);
      else to_d = to_q;
   end

   logic       bl_h, bl_m, bl_s;
   logic       ht_en;
   logic [5:0] sep;

   always_comb begin
      bl_h  = (mode_q == SET_H) ? pulse_500ms : 1'b1;
      bl_m  = (mode_q == SET_M) ? pulse_500ms : 1'b1;
      bl_s  = (mode_q == SET_S) ? pulse_500ms : 1'b1;
      ht_en = bl_h & ~((HOUR_24 == 0) && (hr_q[7:4] == 4'd0));
`ifdef WATCH_COLON_BLINK_EN
      sep = {(mode_q == RUN) ? pulse_500ms : 1'b1, 4'hA, 1'b1};
`else
      sep = 6'b000001;
`endif
      disp_d[7] = {ht_en, hr_q[7:4], 1'b1};
      disp_d[6] = {bl_h, hr_q[3:0], 1'b1};
      disp_d[5] = sep;
      disp_d[4] = {bl_m, mn_q[7:4], 1'b1};
      disp_d[3] = {bl_m, mn_q[3:0], 1'b1};
      disp_d[2] = sep;
      disp_d[1] = {bl_s, sc_q[7:4], 1'b1};
      disp_d[0] = {bl_s, sc_q[3:0], 1'b1};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q      <= RUN;
         hr_q        <= HOUR_RST;
         mn_q        <= 8'h00;
         sc_q        <= 8'h00;
         pm_q        <= 1'b0;
         to_q        <= '0;
         mode_prev_q <= 1'b0;
         btn_prev_q  <= '0;
         rpt_cnt_q   <= '0;
         rpt_arm_q   <= '0;
         disp_q      <= '0;
      end else begin
         mode_q      <= mode_d;
         hr_q        <= hr_d;
         mn_q        <= mn_d;
         sc_q        <= sc_d;
         pm_q        <= pm_d;
         to_q        <= to_d;
         mode_prev_q <= mode_prev_d;
         btn_prev_q  <= btn_prev_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_arm_q   <= rpt_arm_d;
         disp_q      <= disp_d;
      end
   end

   assign d8   = disp_q[7];
   assign d7   = disp_q[6];
   assign d6   = disp_q[5];
   assign d5   = disp_q[4];
   assign d4   = disp_q[3];
   assign d3   = disp_q[2];
   assign d2   = disp_q[1];
   assign d1   = disp_q[0];
   assign pm   = pm_q;
   assign mode = mode_q;

endmodule

// File: tb/tb_watch_core_param.sv
// tb_watch_core_param: directed bench for watch_core_param with a 24h and
// a 12h instance sharing inputs (repeat 10/4 cycles, timeout 3 s).
module tb_watch_core_param;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic pulse_1hz = 1'b0;
   logic pulse_500ms = 1'b1;
   logic mode_button = 1'b0;
   logic add_button = 1'b0;
   logic sub_button = 1'b0;

   logic [5:0] a_d1, a_d2, a_d3, a_d4, a_d5, a_d6, a_d7, a_d8;
   logic [5:0] b_d1, b_d2, b_d3, b_d4, b_d5, b_d6, b_d7, b_d8;
   logic       a_pm, b_pm;
   logic [1:0] a_mode, b_mode;
   logic [47:0] a_disp, b_disp;
   logic [47:0] exp_v;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   watch_core_param #(
      .HOUR_24(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .TIMEOUT_S(3)
   ) dut_24 (
      .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz),
      .pulse_500ms(pulse_500ms), .mode_button(mode_button),
      .add_button(add_button), .sub_button(sub_button),
      .d1(a_d1), .d2(a_d2), .d3(a_d3), .d4(a_d4),
      .d5(a_d5), .d6(a_d6), .d7(a_d7), .d8(a_d8),
      .pm(a_pm), .mode(a_mode)
   );

   watch_core_param #(
      .HOUR_24(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .TIMEOUT_S(3)
   ) dut_12 (
      .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz),
      .pulse_500ms(pulse_500ms), .mode_button(mode_button),
      .add_button(add_button), .sub_button(sub_button),
      .d1(b_d1), .d2(b_d2), .d3(b_d3), .d4(b_d4),
      .d5(b_d5), .d6(b_d6), .d7(b_d7), .d8(b_d8),
      .pm(b_pm), .mode(b_mode)
   );

   assign a_disp = {a_d8, a_d7, a_d6, a_d5, a_d4, a_d3, a_d2, a_d1};
   assign b_disp = {b_d8, b_d7, b_d6, b_d5, b_d4, b_d3, b_d2, b_d1};

   // expected display with all digits visible (blank = 12h leading zero)
   function automatic logic [47:0] exp_run(input logic [7:0] h,
                                           input logic [7:0] m,
                                           input logic [7:0] s,
                                           input logic blank);
      logic [5:0] sep;
`ifdef WATCH_COLON_BLINK_EN
      sep = 6'b110101;
`else
      sep = 6'b000001;
`endif
      return {!(blank && h[7:4] == 4'd0), h[7:4], 1'b1,
              1'b1, h[3:0], 1'b1, sep,
              1'b1, m[7:4], 1'b1, 1'b1, m[3:0], 1'b1, sep,
              1'b1, s[7:4], 1'b1, 1'b1, s[3:0], 1'b1};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // 0 = mode, 1 = add, 2 = sub
   task automatic press(input int which);
      mode_button = (which == 0);
      add_button  = (which == 1);
      sub_button  = (which == 2);
      step(1);
      mode_button = 1'b0;
      add_button  = 1'b0;
      sub_button  = 1'b0;
      step(1);
   endtask

   task automatic tick();
      pulse_1hz = 1'b1;
      step(1);
      pulse_1hz = 1'b0;
      step(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pulse_1hz = 1'b0;
      pulse_500ms = 1'b1;
      mode_button = 1'b0;
      add_button = 1'b0;
      sub_button = 1'b0;
      step(2);
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      checks++;
      if (a_disp !== 48'h0) begin
         errors++;
         $display("FAIL reset_disp24: got %h want 0", a_disp);
      end
      checks++;
      if (b_disp !== 48'h0) begin
         errors++;
         $display("FAIL reset_disp12: got %h want 0", b_disp);
      end
      checks++;
      if (a_mode !== 2'd0 || a_pm !== 1'b0) begin
         errors++;
         $display("FAIL reset_mode_pm: got %0d/%0d want 0/0", a_mode, a_pm);
      end
      reset = 1'b0;
      step(2);
      exp_v = exp_run(8'h00, 8'h00, 8'h00, 1'b0);
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL reset_time24: got %h want %h", a_disp, exp_v);
      end
      exp_v = exp_run(8'h12, 8'h00, 8'h00, 1'b1);
      checks++;
      if (b_disp !== exp_v || b_pm !== 1'b0) begin
         errors++;
         $display("FAIL reset_time12: got %h/%0d want %h/0",
                  b_disp, b_pm, exp_v);
      end
   endtask

   task automatic test_rollover_24();
      do_reset();
      press(0); press(2);
      press(0); press(2);
      press(0); press(2); press(2);
      press(0);
      exp_v = exp_run(8'h23, 8'h59, 8'h58, 1'b0);
      checks++;
      if (a_mode !== 2'd0 || a_disp !== exp_v) begin
         errors++;
         $display("FAIL set_235958: got %0d %h want 0 %h",
                  a_mode, a_disp, exp_v);
      end
      pulse_1hz = 1'b1;
      step(1);
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL disp_latency: got %h want %h", a_disp, exp_v);
      end
      pulse_1hz = 1'b0;
      step(1);
      exp_v = exp_run(8'h23, 8'h59, 8'h59, 1'b0);
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL tick_235959: got %h want %h", a_disp, exp_v);
      end
      tick();
      exp_v = exp_run(8'h00, 8'h00, 8'h00, 1'b0);
      checks++;
      if (a_disp !== exp_v || a_pm !== 1'b0) begin
         errors++;
         $display("FAIL wrap_24: got %h want %h", a_disp, exp_v);
      end
   endtask

   task automatic test_rollover_12();
      do_reset();
      press(0);
      repeat (11) press(1);
      press(0); press(2);
      press(0); press(2);
      press(0);
      exp_v = exp_run(8'h11, 8'h59, 8'h59, 1'b1);
      checks++;
      if (b_disp !== exp_v || b_pm !== 1'b0) begin
         errors++;
         $display("FAIL set_115959: got %h/%0d want %h/0",
                  b_disp, b_pm, exp_v);
      end
      tick();
      exp_v = exp_run(8'h12, 8'h00, 8'h00, 1'b1);
      checks++;
      if (b_disp !== exp_v || b_pm !== 1'b1) begin
         errors++;
         $display("FAIL noon_pm: got %h/%0d want %h/1",
                  b_disp, b_pm, exp_v);
      end
      press(0); press(0); press(2);
      press(0); press(2);
      press(0);
      tick();
      exp_v = exp_run(8'h01, 8'h00, 8'h00, 1'b1);
      checks++;
      if (b_disp !== exp_v || b_pm !== 1'b1) begin
         errors++;
         $display("FAIL wrap_12_01: got %h/%0d want %h/1",
                  b_disp, b_pm, exp_v);
      end
   endtask

   task automatic test_set_repeat();
      do_reset();
      press(0); press(0);
      checks++;
      if (a_mode !== 2'd2) begin
         errors++;
         $display("FAIL enter_set_m: got %0d want 2", a_mode);
      end
      press(2);
      exp_v = exp_run(8'h00, 8'h59, 8'h00, 1'b0);
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL sub_wrap_min: got %h want %h", a_disp, exp_v);
      end
      add_button = 1'b1;
      step(30);
      add_button = 1'b0;
      step(2);
      exp_v = exp_run(8'h00, 8'h05, 8'h00, 1'b0);
      checks++;
      if (a_disp !== exp_v || a_mode !== 2'd2) begin
         errors++;
         $display("FAIL auto_repeat: got %h want %h", a_disp, exp_v);
      end
      pulse_500ms = 1'b0;
      step(2);
      exp_v[29] = 1'b0;
      exp_v[23] = 1'b0;
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL blink_min: got %h want %h", a_disp, exp_v);
      end
      pulse_500ms = 1'b1;
      step(1);
   endtask

   task automatic test_timeout();
      do_reset();
      press(0); press(0); press(0);
      tick(); tick();
      checks++;
      if (a_mode !== 2'd3) begin
         errors++;
         $display("FAIL to_two_ticks: got %0d want 3", a_mode);
      end
      press(1);
      tick(); tick();
      checks++;
      if (a_mode !== 2'd3) begin
         errors++;
         $display("FAIL to_restart: got %0d want 3", a_mode);
      end
      pulse_1hz = 1'b1;
      step(1);
      checks++;
      if (a_mode !== 2'd0) begin
         errors++;
         $display("FAIL to_expire: got %0d want 0", a_mode);
      end
      pulse_1hz = 1'b0;
      step(1);
      exp_v = exp_run(8'h00, 8'h00, 8'h01, 1'b0);
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL to_no_tick: got %h want %h", a_disp, exp_v);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      press(0);
      mode_button = 1'b1;
      add_button = 1'b1;
      step(1);
      mode_button = 1'b0;
      add_button = 1'b0;
      step(1);
      exp_v = exp_run(8'h00, 8'h00, 8'h00, 1'b0);
      checks++;
      if (a_mode !== 2'd2 || a_disp !== exp_v) begin
         errors++;
         $display("FAIL mode_wins: got %0d %h want 2 %h",
                  a_mode, a_disp, exp_v);
      end
      add_button = 1'b1;
      sub_button = 1'b1;
      step(1);
      add_button = 1'b0;
      sub_button = 1'b0;
      step(1);
      checks++;
      if (a_mode !== 2'd2 || a_disp !== exp_v) begin
         errors++;
         $display("FAIL add_sub_cancel: got %0d %h want 2 %h",
                  a_mode, a_disp, exp_v);
      end
      do_reset();
      pulse_1hz = 1'b1;
      mode_button = 1'b1;
      step(1);
      pulse_1hz = 1'b0;
      mode_button = 1'b0;
      step(1);
      exp_v = exp_run(8'h00, 8'h00, 8'h01, 1'b0);
      checks++;
      if (a_mode !== 2'd1 || a_disp !== exp_v) begin
         errors++;
         $display("FAIL tick_and_mode: got %0d %h want 1 %h",
                  a_mode, a_disp, exp_v);
      end
   endtask

   task automatic test_reset_mid_repeat();
      do_reset();
      press(0);
      add_button = 1'b1;
      step(15);
      exp_v = exp_run(8'h02, 8'h00, 8'h00, 1'b0);
      checks++;
      if (a_disp !== exp_v) begin
         errors++;
         $display("FAIL pre_reset_hours: got %h want %h", a_disp, exp_v);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (a_disp !== 48'h0 || b_disp !== 48'h0 || a_mode !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: got %h %h %0d want 0 0 0",
                  a_disp, b_disp, a_mode);
      end
      step(1);
      reset = 1'b0;
      step(20);
      exp_v = exp_run(8'h00, 8'h00, 8'h00, 1'b0);
      checks++;
      if (a_mode !== 2'd0 || a_disp !== exp_v) begin
         errors++;
         $display("FAIL held_after_reset: got %0d %h want 0 %h",
                  a_mode, a_disp, exp_v);
      end
      exp_v = exp_run(8'h12, 8'h00, 8'h00, 1'b1);
      checks++;
      if (b_disp !== exp_v) begin
         errors++;
         $display("FAIL held_after_reset12: got %h want %h", b_disp, exp_v);
      end
      add_button = 1'b0;
      step(1);
   endtask

   initial begin
      test_reset();
      test_rollover_24();
      test_rollover_12();
      test_set_repeat();
      test_timeout();
      test_simultaneous();
      test_reset_mid_repeat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
